// File: rtl/nms_sched_pkg.sv
// ---------------------------------------------------------------------------
// nms_sched_pkg
//   Shared types for the pyramid-level NMS scheduler.
//   state_e : scheduler FSM states
//   pix_t   : per-pixel payload that travels alongside the coordinates
//   level_t : pyramid level index (L0 / L1)
//   dims_ok : accept/reject check applied to a level's programmed size
// ---------------------------------------------------------------------------
package nms_sched_pkg;

    localparam int NLEV = 2;

    typedef enum logic [2:0] {
        IDLE,
        SEL,
        CFG,
        FEED,
        DRAIN,
        DONE
    } state_e;

    typedef logic level_t;

    typedef struct packed {
        logic       st;
        logic [9:0] sc;
    } pix_t;

    // A level is runnable only with a non-empty frame that fits the NMS line buffers.
    function automatic logic dims_ok(input logic [15:0] w, input logic [15:0] h,
                                     input int max_w, input int max_h);
        return (w != 16'd0) && (h != 16'd0) && (int'(w) <= max_w) && (int'(h) <= max_h);
    endfunction

endpackage

// File: rtl/nms_raster_counter.sv
// ---------------------------------------------------------------------------
// nms_raster_counter
//   Tracks raster position (x, y) and linear pixel count of a W x H frame.
//   Ports:
//     clk, rst_n : clock, async active-low reset
//     w, h       : frame dimensions
//     inc        : advance one pixel
//     clr        : return to (0,0), count 0 (wins over inc)
//     x, y       : current raster position
//     cnt        : number of pixels counted so far
//     last       : current position is the final pixel of the frame
// ---------------------------------------------------------------------------
module nms_raster_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [15:0]      w,
    input  logic [15:0]      h,
    input  logic             inc,
    input  logic             clr,
    output logic [15:0]      x,
    output logic [15:0]      y,
    output logic [CNT_W-1:0] cnt,
    output logic             last
);

    logic [15:0]      x_q, x_d;
    logic [15:0]      y_q, y_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             x_wrap;

    assign x_wrap = (x_q == w - 16'd1);

    always_comb begin
        x_d   = x_q;
        y_d   = y_q;
        cnt_d = cnt_q;
        if (clr) begin
            x_d   = '0;
            y_d   = '0;
            cnt_d = '0;
        end else if (inc) begin
            cnt_d = cnt_q + 1'b1;
            if (x_wrap) begin
                x_d = '0;
                y_d = y_q + 16'd1;
            end else begin
                x_d = x_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q   <= '0;
            y_q   <= '0;
            cnt_q <= '0;
        end else begin
            x_q   <= x_d;
            y_q   <= y_d;
            cnt_q <= cnt_d;
        end
    end

    assign x    = x_q;
    assign y    = y_q;
    assign cnt  = cnt_q;
    assign last = x_wrap && (y_q == h - 16'd1);

endmodule

// File: rtl/nms_pyramid_level_scheduler.sv
// ---------------------------------------------------------------------------
// nms_pyramid_level_scheduler
//   Time-shares one 3x3 NMS core between two pyramid-level score streams.
//   Each enabled, validly sized level is run as one job: program NMS cfg,
//   let it settle, forward exactly W*H input pixels, then drain exactly W*H
//   outputs tagged with the level and a last-of-level marker.
//   Ports:
//     start/lvl_en/cfg_w*/cfg_h* : job request, sampled when idle
//     busy/done/err_coord        : job status; err_coord is sticky per job
//     s0_*/s1_*                  : per-level input streams (valid/ready)
//     n_cfg_*, n_s_*, n_m_*      : NMS configuration, NMS input, NMS output
//     m_*                        : tagged output stream (m_level, m_last)
// ---------------------------------------------------------------------------
module nms_pyramid_level_scheduler
    import nms_sched_pkg::*;
#(
    parameter int MAX_W      = 2048,
    parameter int MAX_H      = 1536,
    parameter int CFG_SETTLE = 2,
    parameter int CNT_W      = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [1:0]  lvl_en,
    input  logic [15:0] cfg_w0,
    input  logic [15:0] cfg_h0,
    input  logic [15:0] cfg_w1,
    input  logic [15:0] cfg_h1,
    output logic        busy,
    output logic        done,
    output logic        err_coord,
    input  logic        s0_valid,
    output logic        s0_ready,
    input  logic [15:0] s0_x,
    input  logic [15:0] s0_y,
    input  logic        s0_is_strong,
    input  logic [9:0]  s0_score,
    input  logic        s1_valid,
    output logic        s1_ready,
    input  logic [15:0] s1_x,
    input  logic [15:0] s1_y,
    input  logic        s1_is_strong,
    input  logic [9:0]  s1_score,
    output logic [15:0] n_cfg_w,
    output logic [15:0] n_cfg_h,
    output logic        n_s_valid,
    input  logic        n_s_ready,
    output logic [15:0] n_s_x,
    output logic [15:0] n_s_y,
    output logic        n_s_is_strong,
    output logic [9:0]  n_s_score,
    input  logic        n_m_valid,
    output logic        n_m_ready,
    input  logic [15:0] n_m_x,
    input  logic [15:0] n_m_y,
    input  logic        n_m_is_strong,
    input  logic [9:0]  n_m_score,
    output logic        m_valid,
    input  logic        m_ready,
    output logic [15:0] m_x,
    output logic [15:0] m_y,
    output logic        m_is_strong,
    output logic [9:0]  m_score,
    output logic        m_level,
    output logic        m_last
);

    localparam int SET_W = (CFG_SETTLE > 1) ? $clog2(CFG_SETTLE) : 1;

    state_e                     state_q, state_d;
    logic                       busy_q, busy_d;
    logic                       done_q, done_d;
    logic                       err_q, err_d;
    logic [NLEV-1:0]            en_q, en_d;
    logic [NLEV-1:0]            ran_q, ran_d;
    logic [NLEV-1:0][15:0]      w_q, w_d;
    logic [NLEV-1:0][15:0]      h_q, h_d;
    logic [15:0]                ncfg_w_q, ncfg_w_d;
    logic [15:0]                ncfg_h_q, ncfg_h_d;
    level_t                     lvl_q, lvl_d;
    logic [CNT_W-1:0]           total_q, total_d;
    logic [SET_W-1:0]           settle_q, settle_d;

    logic                       feed, out_act, in_hs, out_hs, cnt_clr;
    logic                       pick_ok;
    level_t                     pick;
    pix_t                       in_pix;
    logic [15:0]                in_x, in_y, out_x, out_y;
    logic [CNT_W-1:0]           in_cnt, out_cnt;
    logic                       in_last, out_last;

    // ---------------- datapath steering (combinational from state) --------
    assign feed     = (state_q == FEED);
    assign out_act  = feed || (state_q == DRAIN);
    assign cnt_clr  = (state_q == SEL);

    always_comb begin
        in_pix = '0;
        if (lvl_q) begin
            in_pix.st = s1_is_strong;
            in_pix.sc = s1_score;
        end else begin
            in_pix.st = s0_is_strong;
            in_pix.sc = s0_score;
        end
    end

    assign n_s_valid     = feed && (lvl_q ? s1_valid : s0_valid);
    assign s0_ready      = feed && !lvl_q && n_s_ready;
    assign s1_ready      = feed &&  lvl_q && n_s_ready;
    assign n_s_x         = lvl_q ? s1_x : s0_x;
    assign n_s_y         = lvl_q ? s1_y : s0_y;
    assign n_s_is_strong = in_pix.st;
    assign n_s_score     = in_pix.sc;
    assign in_hs         = n_s_valid && n_s_ready;

    assign m_valid     = out_act && n_m_valid;
    assign n_m_ready   = out_act && m_ready;
    assign m_x         = n_m_x;
    assign m_y         = n_m_y;
    assign m_is_strong = n_m_is_strong;
    assign m_score     = n_m_score;
    assign m_level     = lvl_q;
    assign m_last      = out_act && out_last;
    assign out_hs      = m_valid && m_ready;

    assign n_cfg_w   = ncfg_w_q;
    assign n_cfg_h   = ncfg_h_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err_coord = err_q;

    // ---------------- raster trackers ------------------------------------
    nms_raster_counter #(.CNT_W(CNT_W)) u_in_ctr (
        .clk  (clk),
        .rst_n(rst_n),
        .w    (ncfg_w_q),
        .h    (ncfg_h_q),
        .inc  (in_hs),
        .clr  (cnt_clr),
        .x    (in_x),
        .y    (in_y),
        .cnt  (in_cnt),
        .last (in_last)
    );

    nms_raster_counter #(.CNT_W(CNT_W)) u_out_ctr (
        .clk  (clk),
        .rst_n(rst_n),
        .w    (ncfg_w_q),
        .h    (ncfg_h_q),
        .inc  (out_hs),
        .clr  (cnt_clr),
        .x    (out_x),
        .y    (out_y),
        .cnt  (out_cnt),
        .last (out_last)
    );

    // Sequencing runs on the counts; the raster positions of the output side
    // and the input-side last flag are informational only.
    logic unused_ctr_bits;
    assign unused_ctr_bits = ^{in_last, out_x, out_y};

    // ---------------- level pick: lowest enabled, not-yet-run, valid -------
    always_comb begin
        pick_ok = 1'b0;
        pick    = '0;
        for (int i = NLEV - 1; i >= 0; i--) begin
            if (en_q[i] && !ran_q[i] && dims_ok(w_q[i], h_q[i], MAX_W, MAX_H)) begin
                pick_ok = 1'b1;
                pick    = level_t'(i);
            end
        end
    end

    // ---------------- FSM next state ---------------------------------------
    always_comb begin
        state_d  = state_q;
        err_d    = err_q;
        en_d     = en_q;
        ran_d    = ran_q;
        w_d      = w_q;
        h_d      = h_q;
        ncfg_w_d = ncfg_w_q;
        ncfg_h_d = ncfg_h_q;
        lvl_d    = lvl_q;
        total_d  = total_q;
        settle_d = settle_q;

        // Count drives sequencing; a coordinate mismatch is only flagged.
        if (in_hs && ((n_s_x != in_x) || (n_s_y != in_y))) begin
            err_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = SEL;
                    en_d    = lvl_en;
                    w_d     = {cfg_w1, cfg_w0};
                    h_d     = {cfg_h1, cfg_h0};
                    ran_d   = '0;
                    err_d   = 1'b0;
                end
            end
            SEL: begin
                if (pick_ok) begin
                    state_d     = CFG;
                    ncfg_w_d    = w_q[pick];
                    ncfg_h_d    = h_q[pick];
                    lvl_d       = pick;
                    total_d     = CNT_W'(w_q[pick]) * CNT_W'(h_q[pick]);
                    ran_d[pick] = 1'b1;
                    settle_d    = '0;
                end else begin
                    state_d = DONE;
                end
            end
            CFG: begin
                if (settle_q == SET_W'(CFG_SETTLE - 1)) begin
                    state_d = FEED;
                end else begin
                    settle_d = settle_q + 1'b1;
                end
            end
            FEED: begin
                if (in_hs && (in_cnt == total_q - CNT_W'(1))) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (out_cnt == total_q) begin
                    state_d = SEL;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d == SEL) || (state_d == CFG) || (state_d == FEED) || (state_d == DRAIN);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            en_q     <= '0;
            ran_q    <= '0;
            w_q      <= '0;
            h_q      <= '0;
            ncfg_w_q <= '0;
            ncfg_h_q <= '0;
            lvl_q    <= '0;
            total_q  <= '0;
            settle_q <= '0;
        end else begin
            state_q  <= state_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
            en_q     <= en_d;
            ran_q    <= ran_d;
            w_q      <= w_d;
            h_q      <= h_d;
            ncfg_w_q <= ncfg_w_d;
            ncfg_h_q <= ncfg_h_d;
            lvl_q    <= lvl_d;
            total_q  <= total_d;
            settle_q <= settle_d;
        end
    end

endmodule

// File: tb/tb_nms_pyramid_level_scheduler.sv
// ---------------------------------------------------------------------------
// tb_nms_pyramid_level_scheduler
//   Directed bench: two raster sources, a small in-order FIFO standing in for
//   the NMS core (echoes inputs, limited depth to create backpressure), and
//   an output monitor that logs every accepted output.
// ---------------------------------------------------------------------------
module tb_nms_pyramid_level_scheduler;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  lvl_en = 2'b00;
    logic [15:0] cfg_w0 = '0, cfg_h0 = '0, cfg_w1 = '0, cfg_h1 = '0;
    logic        busy, done, err_coord;
    logic        s0_valid, s0_ready, s0_is_strong;
    logic [15:0] s0_x, s0_y;
    logic [9:0]  s0_score;
    logic        s1_valid, s1_ready, s1_is_strong;
    logic [15:0] s1_x, s1_y;
    logic [9:0]  s1_score;
    logic [15:0] n_cfg_w, n_cfg_h;
    logic        n_s_valid, n_s_ready, n_s_is_strong;
    logic [15:0] n_s_x, n_s_y;
    logic [9:0]  n_s_score;
    logic        n_m_valid, n_m_ready, n_m_is_strong;
    logic [15:0] n_m_x, n_m_y;
    logic [9:0]  n_m_score;
    logic        m_valid, m_is_strong, m_level, m_last;
    logic        m_ready = 1'b1;
    logic [15:0] m_x, m_y;
    logic [9:0]  m_score;

    nms_pyramid_level_scheduler dut (
        .clk(clk), .rst_n(rst_n), .start(start), .lvl_en(lvl_en),
        .cfg_w0(cfg_w0), .cfg_h0(cfg_h0), .cfg_w1(cfg_w1), .cfg_h1(cfg_h1),
        .busy(busy), .done(done), .err_coord(err_coord),
        .s0_valid(s0_valid), .s0_ready(s0_ready), .s0_x(s0_x), .s0_y(s0_y),
        .s0_is_strong(s0_is_strong), .s0_score(s0_score),
        .s1_valid(s1_valid), .s1_ready(s1_ready), .s1_x(s1_x), .s1_y(s1_y),
        .s1_is_strong(s1_is_strong), .s1_score(s1_score),
        .n_cfg_w(n_cfg_w), .n_cfg_h(n_cfg_h),
        .n_s_valid(n_s_valid), .n_s_ready(n_s_ready), .n_s_x(n_s_x), .n_s_y(n_s_y),
        .n_s_is_strong(n_s_is_strong), .n_s_score(n_s_score),
        .n_m_valid(n_m_valid), .n_m_ready(n_m_ready), .n_m_x(n_m_x), .n_m_y(n_m_y),
        .n_m_is_strong(n_m_is_strong), .n_m_score(n_m_score),
        .m_valid(m_valid), .m_ready(m_ready), .m_x(m_x), .m_y(m_y),
        .m_is_strong(m_is_strong), .m_score(m_score), .m_level(m_level), .m_last(m_last)
    );

    // ---------------- raster sources ----------------
    int   idx0 = 0, idx1 = 0;
    int   sw0 = 0, sh0 = 0, sw1 = 0, sh1 = 0;
    int   bad0 = -1;
    logic src_load = 1'b0;

    assign s0_valid     = (idx0 < sw0 * sh0);
    assign s0_x         = 16'((sw0 == 0) ? 0 : (idx0 % sw0 + ((idx0 == bad0) ? 1 : 0)));
    assign s0_y         = 16'((sw0 == 0) ? 0 : (idx0 / sw0));
    assign s0_is_strong = idx0[0];
    assign s0_score     = 10'(idx0 + 100);
    assign s1_valid     = (idx1 < sw1 * sh1);
    assign s1_x         = 16'((sw1 == 0) ? 0 : (idx1 % sw1));
    assign s1_y         = 16'((sw1 == 0) ? 0 : (idx1 / sw1));
    assign s1_is_strong = idx1[0];
    assign s1_score     = 10'(idx1 + 300);

    always @(posedge clk) begin
        if (src_load) begin
            idx0 <= 0;
            idx1 <= 0;
        end else begin
            if (s0_valid && s0_ready) idx0 <= idx0 + 1;
            if (s1_valid && s1_ready) idx1 <= idx1 + 1;
        end
    end

    // ---------------- NMS stand-in: 4-deep in-order echo FIFO ----------------
    logic [42:0] fifo_mem [0:15];
    logic [4:0]  wr_p, rd_p, fcnt;
    assign fcnt      = wr_p - rd_p;
    assign n_s_ready = (fcnt < 5'd4);
    assign n_m_valid = (fcnt != 5'd0);
    assign {n_m_x, n_m_y, n_m_is_strong, n_m_score} = fifo_mem[rd_p[3:0]];

    always @(posedge clk) begin
        if (n_s_valid && n_s_ready)
            fifo_mem[wr_p[3:0]] <= {n_s_x, n_s_y, n_s_is_strong, n_s_score};
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_p <= '0;
            rd_p <= '0;
        end else begin
            if (n_s_valid && n_s_ready) wr_p <= wr_p + 5'd1;
            if (n_m_valid && n_m_ready) rd_p <= rd_p + 5'd1;
        end
    end

    // ---------------- output ready pattern ----------------
    logic rnd_mode = 1'b0;
    always @(posedge clk) m_ready <= rnd_mode ? ($urandom_range(0, 3) != 0) : 1'b1;

    // ---------------- monitor ----------------
    logic [15:0] obs_x [0:511];
    logic [15:0] obs_y [0:511];
    logic        obs_lv [0:511];
    logic        obs_last [0:511];
    int obs_n = 0, done_cnt = 0, last_cnt = 0, s0_rdy_cyc = 0, s0_stall = 0;

    always @(posedge clk) begin
        if (m_valid && m_ready && obs_n < 512) begin
            obs_x[obs_n]    <= m_x;
            obs_y[obs_n]    <= m_y;
            obs_lv[obs_n]   <= m_level;
            obs_last[obs_n] <= m_last;
            obs_n           <= obs_n + 1;
            if (m_last) last_cnt <= last_cnt + 1;
            $display("out #%0d lvl=%0d x=%0d y=%0d last=%0d", obs_n, m_level, m_x, m_y, m_last);
        end
        if (done) done_cnt <= done_cnt + 1;
        if (s0_ready) s0_rdy_cyc <= s0_rdy_cyc + 1;
        if (s0_valid && n_s_valid && !s0_ready) s0_stall <= s0_stall + 1;
    end

    // ---------------- checking helpers ----------------
    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic run_job(input logic [1:0] en, input int w0, input int h0, input int w1, input int h1);
        @(negedge clk);
        sw0 = w0; sh0 = h0; sw1 = w1; sh1 = h1;
        src_load = 1'b1;
        @(negedge clk);
        src_load = 1'b0;
        lvl_en = en;
        cfg_w0 = 16'(w0); cfg_h0 = 16'(h0); cfg_w1 = 16'(w1); cfg_h1 = 16'(h1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        $display("job en=%b L0=%0dx%0d L1=%0dx%0d started", en, w0, h0, w1, h1);
    endtask

    task automatic wait_done(input int lim, input string tag);
        int c;
        c = 0;
        while (done !== 1'b1 && c < lim) begin
            @(negedge clk);
            c++;
        end
        check({tag, "_done_seen"}, 64'(done), 64'd1);
    endtask

    // Expected outputs of one level: raster order, last only on the final pixel.
    task automatic check_frame(input string tag, input int base_i, input int lv, input int w, input int h);
        for (int i = 0; i < w * h; i++) begin
            logic [33:0] e;
            logic [33:0] o;
            e = {lv[0], (i == w * h - 1), 16'(i % w), 16'(i / w)};
            o = {obs_lv[base_i + i], obs_last[base_i + i], obs_x[base_i + i], obs_y[base_i + i]};
            check($sformatf("%s_px%0d", tag, i), 64'(o), 64'(e));
        end
    endtask

    // ---------------- directed sequence ----------------
    int base, dbase, lbase, rbase, sbase;
    logic found;

    initial begin
        // Reset state
        tick(3);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_err", 64'(err_coord), 64'd0);
        check("rst_cfg_w", 64'(n_cfg_w), 64'd0);
        check("rst_level", 64'(m_level), 64'd0);
        check("rst_valids", 64'({m_valid, n_s_valid, s0_ready, s1_ready, n_m_ready}), 64'd0);
        rst_n = 1'b1;
        tick(2);

        // T1: both levels, ideal ready
        base = obs_n; dbase = done_cnt; lbase = last_cnt;
        run_job(2'b11, 4, 3, 2, 2);
        wait_done(500, "t1");
        tick(2);
        check("t1_count", 64'(obs_n - base), 64'd16);
        check_frame("t1_l0", base, 0, 4, 3);
        check_frame("t1_l1", base + 12, 1, 2, 2);
        check("t1_done_pulses", 64'(done_cnt - dbase), 64'd1);
        check("t1_last_cnt", 64'(last_cnt - lbase), 64'd2);
        check("t1_err", 64'(err_coord), 64'd0);
        check("t1_busy_end", 64'(busy), 64'd0);

        // T2: L0 disabled; L0 source offers pixels but must never be accepted
        base = obs_n; rbase = s0_rdy_cyc;
        run_job(2'b10, 8, 2, 3, 2);
        tick(2);
        check("t2_cfg_w", 64'(n_cfg_w), 64'd3);
        check("t2_cfg_h", 64'(n_cfg_h), 64'd2);
        check("t2_level", 64'(m_level), 64'd1);
        wait_done(500, "t2");
        tick(2);
        check("t2_count", 64'(obs_n - base), 64'd6);
        check_frame("t2_l1", base, 1, 3, 2);
        check("t2_s0_ready_cycles", 64'(s0_rdy_cyc - rbase), 64'd0);

        // T3a: L1 width zero -> only L0 runs
        base = obs_n; dbase = done_cnt;
        run_job(2'b11, 2, 2, 0, 2);
        wait_done(500, "t3a");
        tick(2);
        check("t3a_count", 64'(obs_n - base), 64'd4);
        check_frame("t3a_l0", base, 0, 2, 2);
        check("t3a_done_pulses", 64'(done_cnt - dbase), 64'd1);

        // T3b: both widths zero -> done two cycles after start
        run_job(2'b11, 0, 3, 0, 3);
        check("t3b_busy_c1", 64'({busy, done}), 64'b10);
        tick(1);
        check("t3b_busy_done_c2", 64'({busy, done}), 64'b01);
        tick(1);
        check("t3b_done_c3", 64'({busy, done}), 64'b00);

        // T4: random output backpressure on a 16x8 L0 frame
        base = obs_n; lbase = last_cnt; sbase = s0_stall;
        rnd_mode = 1'b1;
        run_job(2'b01, 16, 8, 0, 0);
        wait_done(5000, "t4");
        rnd_mode = 1'b0;
        tick(2);
        check("t4_count", 64'(obs_n - base), 64'd128);
        check_frame("t4_l0", base, 0, 16, 8);
        check("t4_last_cnt", 64'(last_cnt - lbase), 64'd1);
        check("t4_s0_stalled", 64'((s0_stall - sbase) > 0), 64'd1);

        // T5: raster mismatch at position (1,0)
        base = obs_n;
        bad0 = 1;
        run_job(2'b01, 4, 4, 0, 0);
        wait_done(500, "t5");
        bad0 = -1;
        tick(2);
        check("t5_err", 64'(err_coord), 64'd1);
        check("t5_count", 64'(obs_n - base), 64'd16);

        // T6: reset in the middle of L1 feeding
        run_job(2'b11, 2, 2, 4, 4);
        check("t6_err_cleared", 64'(err_coord), 64'd0);
        found = 1'b0;
        for (int c = 0; c < 300 && !found; c++) begin
            @(negedge clk);
            if (s1_ready === 1'b1) found = 1'b1;
        end
        check("t6_l1_feed_reached", 64'(found), 64'd1);
        rst_n = 1'b0;
        #1;
        check("t6_rst_busy", 64'(busy), 64'd0);
        check("t6_rst_valids", 64'({m_valid, n_s_valid, s0_ready, s1_ready, n_m_ready}), 64'd0);
        tick(3);
        rst_n = 1'b1;
        tick(1);
        check("t6_rst_cfg", 64'({n_cfg_w, n_cfg_h}), 64'd0);
        base = obs_n;
        run_job(2'b11, 2, 2, 2, 2);
        wait_done(500, "t6");
        tick(2);
        check("t6_count", 64'(obs_n - base), 64'd8);
        check_frame("t6_l0", base, 0, 2, 2);
        check_frame("t6_l1", base + 4, 1, 2, 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
